// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: row serialiser for the LED streamer.
// Each row goes out as a 16-bit header {nx_m1, ny_m1, 2'b00, row} followed by
// W = (nx+1)*(ny+1) payload words, MSB first. The words are prefetched from the
// line buffer into a small FIFO. Rows run 0..ROWS-1 back to back while enabled.
//
// Parameters: ROWS (1..64) rows per frame; FIFO_DEPTH (2..4) words buffered+outstanding.
// Ports:
//   i2s_clk, rst        clock, synchronous active-high reset
//   enable              run frames; checked in IDLE and at frame end
//   nx_m1, ny_m1        geometry, latched on IDLE->HDR
//   i2s_data            registered serial stream
//   pix_req, pix_addr   fetch request, address {row[5:0], word_idx[7:0]}
//   pix_word, pix_valid in-order fetch response
//   busy                high outside IDLE (aligned with i2s_data)
//   frame_done          pulse in the cycle after the last bit of row ROWS-1
//   underrun            sticky, set when a payload slot found the FIFO empty
// Optional macro I2S_FRAME_TX_UNDERRUN_CNT_EN adds underrun_cnt[15:0], a
// saturating count of underrun slots.
module i2s_frame_tx #(
  parameter int ROWS       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i2s_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  nx_m1,
  input  logic [3:0]  ny_m1,
  output logic        i2s_data,
  output logic        pix_req,
  output logic [13:0] pix_addr,
  input  logic [15:0] pix_word,
  input  logic        pix_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int          PW       = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);
  localparam logic [3:0]  DEPTH4   = 4'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                       state;
  logic [3:0]                   nx_q, ny_q;
  logic [5:0]                   row;
  logic [11:0]                  bcnt;      // header bit k or payload bit index
  logic [15:0]                  shreg;
  logic                         fd_pend;
  logic [FIFO_DEPTH-1:0][15:0]  mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [3:0]                   buf_cnt, out_cnt, disc_cnt;
  logic [5:0]                   f_row;
  logic [7:0]                   f_idx;

  logic [7:0]  wm1;
  logic [15:0] hdr_word;
  logic        pop, empty, urun, accept, drop, push, do_pop, req, pay_last;
  logic [3:0]  disc_eff, out_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // W-1 fits 8 bits even for W=256, so the word counter never overflows.
  assign wm1      = 8'((9'(nx_q) + 9'd1) * (9'(ny_q) + 9'd1) - 9'd1);
  assign hdr_word = {nx_q, ny_q, 2'b00, row};

  assign pop      = (state == PAY) && (bcnt[3:0] == 4'd0);
  assign empty    = (buf_cnt == 4'd0);
  assign urun     = pop && empty;
  assign do_pop   = pop && !empty;
  // Responses only count while something is outstanding, so stale valids after
  // reset fall on the floor.
  assign accept   = pix_valid && (out_cnt != 4'd0);
  // An underrun slot owes one discard; a word landing in that same cycle pays it.
  assign disc_eff = disc_cnt + {3'b0, urun};
  assign drop     = accept && (disc_eff != 4'd0);
  assign push     = accept && !drop;
  assign req      = (state != IDLE) && ((buf_cnt + out_cnt) < DEPTH4);
  assign out_nxt  = out_cnt + {3'b0, req} - {3'b0, accept};
  assign pay_last = (state == PAY) && (bcnt == {wm1, 4'hF});

  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      state      <= IDLE;
      nx_q       <= '0;
      ny_q       <= '0;
      row        <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      fd_pend    <= 1'b0;
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      buf_cnt    <= '0;
      out_cnt    <= '0;
      disc_cnt   <= '0;
      f_row      <= '0;
      f_idx      <= '0;
      i2s_data   <= 1'b0;
      pix_req    <= 1'b0;
      pix_addr   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
      underrun_cnt <= '0;
`endif
    end else begin
      frame_done <= fd_pend;
      fd_pend    <= 1'b0;
      busy       <= (state != IDLE);

      // Fetch engine: free-running address walk with row wrap.
      pix_req <= req;
      if (req) begin
        pix_addr <= {f_row, f_idx};
        if (f_idx == wm1) begin
          f_idx <= '0;
          f_row <= (f_row == ROW_LAST) ? 6'd0 : f_row + 6'd1;
        end else begin
          f_idx <= f_idx + 8'd1;
        end
      end

      // Prefetch FIFO
      if (push) begin
        mem[wr_ptr] <= pix_word;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      buf_cnt  <= buf_cnt + {3'b0, push} - {3'b0, do_pop};
      out_cnt  <= out_nxt;
      disc_cnt <= drop ? disc_eff - 4'd1 : disc_eff;

      if (urun) begin
        underrun <= 1'b1;
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`endif
      end

      case (state)
        IDLE: begin
          i2s_data <= 1'b0;
          if (enable) begin
            state    <= HDR;
            nx_q     <= nx_m1;
            ny_q     <= ny_m1;
            row      <= '0;
            bcnt     <= '0;
            f_row    <= '0;
            f_idx    <= '0;
            // Flush prefetched words; anything still in flight is dropped on arrival.
            buf_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            disc_cnt <= out_nxt;
          end
        end
        HDR: begin
          i2s_data <= hdr_word[4'd15 - bcnt[3:0]];
          if (bcnt[3:0] == 4'd15) begin
            state <= PAY;
            bcnt  <= '0;
          end else begin
            bcnt <= bcnt + 12'd1;
          end
        end
        PAY: begin
          if (pop) begin
            // An empty slot sends 16 zeros so later slots stay address-aligned.
            i2s_data <= empty ? 1'b0 : mem[rd_ptr][15];
            shreg    <= empty ? 16'h0000 : {mem[rd_ptr][14:0], 1'b0};
          end else begin
            i2s_data <= shreg[15];
            shreg    <= {shreg[14:0], 1'b0};
          end
          if (pay_last) begin
            bcnt  <= '0;
            state <= HDR;
            if (row == ROW_LAST) begin
              row     <= '0;
              fd_pend <= 1'b1;
              if (!enable) state <= IDLE;
            end else begin
              row <= row + 6'd1;
            end
          end else begin
            bcnt <= bcnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Directed bench for i2s_frame_tx (ROWS=4, FIFO_DEPTH=2) with an in-order
// line-buffer responder of configurable latency.
module tb_i2s_frame_tx;
  localparam int ROWS = 4;

  logic        i2s_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  nx_m1 = '0, ny_m1 = '0;
  logic        i2s_data, pix_req, busy, frame_done, underrun;
  logic [13:0] pix_addr;
  logic [15:0] pix_word;
  logic        pix_valid;
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  i2s_frame_tx #(.ROWS(ROWS), .FIFO_DEPTH(2)) dut (
    .i2s_clk(i2s_clk), .rst(rst), .enable(enable), .nx_m1(nx_m1), .ny_m1(ny_m1),
    .i2s_data(i2s_data), .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_word(pix_word), .pix_valid(pix_valid), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 i2s_clk = ~i2s_clk;

  int          checks = 0, errors = 0;
  int unsigned cyc = 0;
  always @(posedge i2s_clk) cyc <= cyc + 1;

  // Responder controls (written only by the test sequence)
  int unsigned lat = 1;
  logic        hold_on = 1'b0;
  logic [13:0] hold_addr = '0;
  logic        inject = 1'b0;

  typedef struct { logic [13:0] addr; int unsigned due; } rq_t;
  rq_t         rq_q[$];
  logic [13:0] req_log[$];

  function automatic logic [15:0] pattern(input logic [13:0] a);
    case (a)
      14'h000: return 16'hA5C3;
      14'h100: return 16'h0F0F;
      default: return {a[7:0], 2'b11, a[13:8]} ^ 16'h5A5A;
    endcase
  endfunction

  initial begin
    pix_valid = 1'b0;
    pix_word  = '0;
    forever begin
      @(posedge i2s_clk); #1;
      pix_valid = 1'b0;
      if (inject) begin
        pix_valid = 1'b1;
        pix_word  = 16'hDEAD;
      end else if (rq_q.size() > 0 && rq_q[0].due <= cyc) begin
        rq_t h;
        h = rq_q.pop_front();
        pix_valid = 1'b1;
        pix_word  = pattern(h.addr);
      end
      if (pix_req) begin
        rq_t n;
        n.addr = pix_addr;
        n.due  = cyc + lat + ((hold_on && pix_addr == hold_addr) ? 40 : 0);
        rq_q.push_back(n);
        req_log.push_back(pix_addr);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i2s_clk); #1;
  endtask

  task automatic get_word(output logic [15:0] w);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      w = {w[14:0], i2s_data};
    end
  endtask

  task automatic start(input logic [3:0] nx, input logic [3:0] ny);
    nx_m1 = nx; ny_m1 = ny; enable = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (i2s_data !== 1'b0) begin errors++; $display("FAIL rst_data: got %b expected 0", i2s_data); end
    checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", pix_req); end
    checks++; if (pix_addr !== 14'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", pix_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b expected 0", frame_done); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_urun: got %b expected 0", underrun); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    logic [15:0] w, exp;
    logic fd1, fd2;
    lat = 1;
    start(4'd0, 4'd0);
    for (int r = 0; r < ROWS; r++) begin
      get_word(w);
      exp = {10'h0, 6'(r)};
      checks++; if (w !== exp) begin errors++; $display("FAIL basic_hdr%0d: got %h expected %h", r, w, exp); end
      if (r == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
      end
      get_word(w);
      exp = pattern({6'(r), 8'h00});
      checks++; if (w !== exp) begin errors++; $display("FAIL basic_pay%0d: got %h expected %h", r, w, exp); end
    end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_early: got %b expected 0", frame_done); end
    tick(); fd1 = frame_done; w = {15'h0, i2s_data};
    tick(); fd2 = frame_done; w = {w[14:0], i2s_data};
    for (int i = 0; i < 14; i++) begin tick(); w = {w[14:0], i2s_data}; end
    checks++; if (fd1 !== 1'b1) begin errors++; $display("FAIL basic_fd: got %b expected 1", fd1); end
    checks++; if (fd2 !== 1'b0) begin errors++; $display("FAIL basic_fd_pulse: got %b expected 0", fd2); end
    checks++; if (w !== 16'h0000) begin errors++; $display("FAIL basic_next_hdr: got %h expected 0000", w); end
    do_reset();
  endtask

  task automatic test_max_geometry();
    logic [15:0] w, exp;
    int bad;
    logic [13:0] ea;
    lat = 2;
    req_log.delete();
    start(4'hF, 4'hF);
    get_word(w);
    checks++; if (w !== 16'hFF00) begin errors++; $display("FAIL max_hdr0: got %h expected ff00", w); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      get_word(w);
      exp = pattern({6'd0, 8'(i)});
      if (w !== exp) begin
        if (bad == 0) $display("max slot %0d: got %h want %h", i, w, exp);
        bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL max_payload: got %0d bad words expected 0", bad); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL max_urun: got %b expected 0", underrun); end
    get_word(w);
    checks++; if (w !== 16'hFF01) begin errors++; $display("FAIL max_hdr1: got %h expected ff01", w); end
    bad = 0;
    if (req_log.size() < 258) bad = 999;
    else for (int i = 0; i < 258; i++) begin
      ea = (i < 256) ? {6'd0, 8'(i)} : {6'd1, 8'(i - 256)};
      if (req_log[i] !== ea) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL max_addr_seq: got %0d bad (log %0d) expected 0", bad, req_log.size()); end
    do_reset();
    lat = 1;
  endtask

  task automatic test_underrun();
    logic [15:0] w, exp;
    lat = 1;
    hold_addr = 14'h001; hold_on = 1'b1;
    start(4'd1, 4'd1);
    get_word(w);
    checks++; if (w !== 16'h1100) begin errors++; $display("FAIL ur_hdr0: got %h expected 1100", w); end
    get_word(w); exp = pattern(14'h000);
    checks++; if (w !== exp) begin errors++; $display("FAIL ur_slot0: got %h expected %h", w, exp); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_flag0: got %b expected 0", underrun); end
    get_word(w);
    checks++; if (w !== 16'h0000) begin errors++; $display("FAIL ur_slot1: got %h expected 0000", w); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag1: got %b expected 1", underrun); end
    hold_on = 1'b0;
    get_word(w); exp = pattern(14'h002);
    checks++; if (w !== exp) begin errors++; $display("FAIL ur_slot2: got %h expected %h", w, exp); end
    get_word(w); exp = pattern(14'h003);
    checks++; if (w !== exp) begin errors++; $display("FAIL ur_slot3: got %h expected %h", w, exp); end
    get_word(w);
    checks++; if (w !== 16'h1101) begin errors++; $display("FAIL ur_hdr1: got %h expected 1101", w); end
    get_word(w); exp = pattern(14'h100);
    checks++; if (w !== exp) begin errors++; $display("FAIL ur_row1_slot0: got %h expected %h", w, exp); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL ur_cnt: got %0d expected 1", underrun_cnt); end
`endif
    do_reset();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clr: got %b expected 0", underrun); end
  endtask

  task automatic test_enable_drop();
    logic [15:0] w, exp;
    int nreq, ndata, nbusy;
    lat = 1;
    start(4'd0, 4'd0);
    for (int r = 0; r < ROWS; r++) begin
      get_word(w);
      if (r == 0) enable = 1'b0;
      exp = {10'h0, 6'(r)};
      checks++; if (w !== exp) begin errors++; $display("FAIL drop_hdr%0d: got %h expected %h", r, w, exp); end
      get_word(w);
      exp = pattern({6'(r), 8'h00});
      checks++; if (w !== exp) begin errors++; $display("FAIL drop_pay%0d: got %h expected %h", r, w, exp); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_last: got %b expected 1", busy); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL drop_fd: got %b expected 1", frame_done); end
    nreq = 0; ndata = 0; nbusy = 0;
    if (pix_req) nreq++;
    if (i2s_data) ndata++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pix_req) nreq++;
      if (i2s_data) ndata++;
      if (busy) nbusy++;
    end
    checks++; if (nbusy !== 0) begin errors++; $display("FAIL drop_busy: got %0d busy cycles expected 0", nbusy); end
    checks++; if (ndata !== 0) begin errors++; $display("FAIL drop_data: got %0d ones expected 0", ndata); end
    checks++; if (nreq !== 0) begin errors++; $display("FAIL drop_req: got %0d requests expected 0", nreq); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w, exp;
    logic [6:0] b7;
    int nreq, bad;
    lat = 1;
    start(4'd0, 4'd0);
    get_word(w); get_word(w); get_word(w);
    checks++; if (w !== 16'h0001) begin errors++; $display("FAIL rm_hdr1: got %h expected 0001", w); end
    b7 = '0;
    for (int i = 0; i < 7; i++) begin tick(); b7 = {b7[5:0], i2s_data}; end
    checks++; if (b7 !== 7'b0000111) begin errors++; $display("FAIL rm_bits: got %b expected 0000111", b7); end
    rst = 1'b1;
    tick();
    checks++; if ({i2s_data, pix_req, pix_addr, busy, frame_done, underrun} !== 19'h0) begin
      errors++; $display("FAIL rm_outputs: got data=%b req=%b addr=%h busy=%b fd=%b ur=%b expected all 0",
                         i2s_data, pix_req, pix_addr, busy, frame_done, underrun);
    end
    rst = 1'b0; enable = 1'b0;
    nreq = 0;
    inject = 1'b1;
    repeat (3) begin tick(); if (pix_req || busy) nreq++; end
    inject = 1'b0;
    repeat (6) begin tick(); if (pix_req || busy) nreq++; end
    checks++; if (nreq !== 0) begin errors++; $display("FAIL rm_idle: got %0d active cycles expected 0", nreq); end
    start(4'd2, 4'd1);
    get_word(w);
    checks++; if (w !== 16'h2100) begin errors++; $display("FAIL rm_restart_hdr: got %h expected 2100", w); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      get_word(w);
      exp = pattern({6'd0, 8'(i)});
      if (w !== exp) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rm_restart_pay: got %0d bad words expected 0", bad); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rm_urun: got %b expected 0", underrun); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_geometry();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
